// File: rtl/udp_echo_pkg.sv
// udp_echo_pkg: shared types for the UDP echo buffer.
// Descriptor bundle, read FSM states and pointer-width helper.
package udp_echo_pkg;

  typedef struct packed {
    logic [15:0] len;
    logic [31:0] ip;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } rd_state_t;

  // One extra bit separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/udp_pkt_desc_fifo.sv
// udp_pkt_desc_fifo: synchronous FIFO of committed-packet descriptors.
// Ports: i_clk/i_rst, i_push/i_din, i_pop/o_dout (show-ahead), o_full, o_empty.
module udp_pkt_desc_fifo
  import udp_echo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_push,
  input  desc_t i_din,
  input  logic  i_pop,
  output desc_t o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int AW = $clog2(DEPTH);

  desc_t      r_mem [DEPTH];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic       w_do_pop;
  logic       w_do_push;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_dout  = r_mem[r_rp[AW-1:0]];

  // A pop frees the slot the push lands in when full.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wp[AW-1:0]] <= i_din;
        r_wp <= r_wp + 1'b1;
      end
      if (w_do_pop) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_echo_buffer.sv
// udp_echo_buffer: store-and-forward UDP payload buffer, whole-packet drop.
// Ports: udp_r* receive stream in, udp_t* transmit stream out, pkt/drop counters.
module udp_echo_buffer
  import udp_echo_pkg::*;
#(
  parameter int BUF_DEPTH   = 2048,
  parameter int MAX_PKT_LEN = 1472,
  parameter int DESC_DEPTH  = 4
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [7:0]  udp_rdata_in,
  input  logic        udp_rvalid_in,
  output logic        udp_rready_out,
  input  logic        udp_rlast_in,
  input  logic [31:0] udp_rip_in,
  output logic [7:0]  udp_tdata_out,
  output logic        udp_tvalid_out,
  input  logic        udp_tready_in,
  output logic        udp_tlast_out,
  output logic [31:0] udp_tip_out,
  output logic [15:0] pkt_cnt_out,
  output logic [15:0] drop_cnt_out
);

  localparam int PW = ptr_w(BUF_DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] P_DEPTH = PW'(BUF_DEPTH);
  localparam logic [15:0]   P_MAX   = 16'(MAX_PKT_LEN);

  logic [7:0]    r_mem [BUF_DEPTH];
  logic          r_rdy;
  logic          r_sop;
  logic          r_bad;
  logic [15:0]   r_len;
  logic [31:0]   r_ip;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_rd_ptr;
  logic [15:0]   r_pkt_cnt;
  logic [15:0]   r_drop_cnt;
  rd_state_t     r_state;
  rd_state_t     w_state_nxt;
  logic [15:0]   r_rem;
  logic [31:0]   r_tip;
  logic [7:0]    r_q;

  logic          w_acc;
  logic [PW-1:0] w_free;
  logic [15:0]   w_len_cur;
  logic [31:0]   w_ip_cur;
  logic          w_bad;
  logic          w_wr_en;
  logic          w_push;
  logic          w_pop;
  logic          w_hs;
  logic [PW-1:0] w_raddr;
  desc_t         w_din;
  desc_t         w_dout;
  logic          w_dfull;
  logic          w_dempty;

  // ---------------- write side ----------------
  assign w_acc     = udp_rvalid_in & r_rdy & ~logic_rst;
  assign w_free    = P_DEPTH - (r_wr_ptr - r_rd_ptr);
  assign w_len_cur = r_sop ? 16'd0 : r_len;
  assign w_ip_cur  = r_sop ? udp_rip_in : r_ip;

  // Descriptor full only blocks if the reader is not popping this cycle.
  assign w_bad = (~r_sop & r_bad) |
                 (w_free == '0) |
                 (w_len_cur == P_MAX) |
                 (udp_rlast_in & w_dfull & ~w_pop);

  assign w_wr_en = w_acc & ~w_bad;
  assign w_push  = w_wr_en & udp_rlast_in;
  assign w_din   = '{len: w_len_cur + 16'd1, ip: w_ip_cur};

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      r_rdy       <= 1'b0;
      r_sop       <= 1'b1;
      r_bad       <= 1'b0;
      r_len       <= '0;
      r_ip        <= '0;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_acc) begin
        r_ip  <= w_ip_cur;
        r_bad <= w_bad;
        r_sop <= udp_rlast_in;
        r_len <= w_wr_en ? w_len_cur + 16'd1 : w_len_cur;
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (udp_rlast_in) begin
          if (w_bad) begin
            r_wr_ptr   <= r_wr_commit;
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end else begin
            r_wr_commit <= r_wr_ptr + 1'b1;
            r_pkt_cnt   <= r_pkt_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge logic_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= udp_rdata_in;
    end
  end

  udp_pkt_desc_fifo #(
    .DEPTH(DESC_DEPTH)
  ) u_desc (
    .i_clk  (logic_clk),
    .i_rst  (logic_rst),
    .i_push (w_push),
    .i_din  (w_din),
    .i_pop  (w_pop),
    .o_dout (w_dout),
    .o_full (w_dfull),
    .o_empty(w_dempty)
  );

  // ---------------- read side ----------------
  // r_q always holds mem[r_rd_ptr]; on a handshake the next byte is
  // fetched so the stream stays gap-free, otherwise the same byte is
  // re-read, which keeps tdata stable during a stall.
  assign w_hs = (r_state == SEND) & udp_tready_in;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_raddr     = r_rd_ptr;
    unique case (r_state)
      IDLE: begin
        if (!w_dempty) begin
          w_pop       = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_state_nxt = SEND;
      end
      SEND: begin
        if (w_hs) begin
          w_raddr = r_rd_ptr + 1'b1;
          if (r_rem == 16'd1) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      r_state  <= IDLE;
      r_rd_ptr <= '0;
      r_rem    <= '0;
      r_tip    <= '0;
      r_q      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= r_mem[w_raddr[AW-1:0]];
      if (w_pop) begin
        r_tip <= w_dout.ip;
        r_rem <= w_dout.len;
      end
      if (w_hs) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rem    <= r_rem - 16'd1;
      end
    end
  end

  assign udp_rready_out = r_rdy;
  assign udp_tvalid_out = (r_state == SEND);
  assign udp_tlast_out  = (r_state == SEND) && (r_rem == 16'd1);
  assign udp_tdata_out  = r_q;
  assign udp_tip_out    = r_tip;
  assign pkt_cnt_out    = r_pkt_cnt;
  assign drop_cnt_out   = r_drop_cnt;

endmodule

// File: tb/tb_udp_echo_buffer.sv
// tb_udp_echo_buffer: scoreboard bench for udp_echo_buffer.
// Driver pushes expected beats; negedge monitor pops and compares.
module tb_udp_echo_buffer;

  logic        logic_clk = 1'b0;
  logic        logic_rst = 1'b1;
  logic [7:0]  udp_rdata_in = '0;
  logic        udp_rvalid_in = 1'b0;
  logic        udp_rready_out;
  logic        udp_rlast_in = 1'b0;
  logic [31:0] udp_rip_in = '0;
  logic [7:0]  udp_tdata_out;
  logic        udp_tvalid_out;
  logic        udp_tready_in = 1'b1;
  logic        udp_tlast_out;
  logic [31:0] udp_tip_out;
  logic [15:0] pkt_cnt_out;
  logic [15:0] drop_cnt_out;

  udp_echo_buffer dut (
    .logic_clk     (logic_clk),
    .logic_rst     (logic_rst),
    .udp_rdata_in  (udp_rdata_in),
    .udp_rvalid_in (udp_rvalid_in),
    .udp_rready_out(udp_rready_out),
    .udp_rlast_in  (udp_rlast_in),
    .udp_rip_in    (udp_rip_in),
    .udp_tdata_out (udp_tdata_out),
    .udp_tvalid_out(udp_tvalid_out),
    .udp_tready_in (udp_tready_in),
    .udp_tlast_out (udp_tlast_out),
    .udp_tip_out   (udp_tip_out),
    .pkt_cnt_out   (pkt_cnt_out),
    .drop_cnt_out  (drop_cnt_out)
  );

  always #5 logic_clk = ~logic_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;
  bit lat_arm = 0;
  bit rand_tready = 0;
  int out_bytes = 0;
  int out_pkts = 0;
  logic [40:0] sb [$];

  bit          prev_stall = 0;
  bit          prev_hs = 0;
  logic [7:0]  p_data;
  logic        p_last;
  logic [31:0] p_ip;

  always @(posedge logic_clk) cyc++;

  always @(posedge logic_clk) begin
    if (rand_tready) begin
      #1;
      udp_tready_in = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  // Monitor: samples at negedge, i.e. the values the next edge acts on.
  always @(negedge logic_clk) begin
    logic [40:0] e;
    if (logic_rst) begin
      prev_stall = 0;
      prev_hs = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold",
            {udp_tvalid_out, udp_tlast_out, udp_tdata_out, udp_tip_out},
            {1'b1, p_last, p_data, p_ip});
      if (prev_hs)
        chk("no_gap", 64'(udp_tvalid_out), 64'd1);
      if (lat_arm && udp_tvalid_out) begin
        chk("latency", 64'(cyc + 1 - last_edge), 64'd3);
        lat_arm = 0;
      end
      prev_stall = udp_tvalid_out & ~udp_tready_in;
      p_data = udp_tdata_out;
      p_last = udp_tlast_out;
      p_ip = udp_tip_out;
      prev_hs = 0;
      if (udp_tvalid_out && udp_tready_in) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %0h want none", udp_tdata_out);
        end else begin
          e = sb.pop_front();
          chk("beat", {udp_tdata_out, udp_tlast_out, udp_tip_out}, 64'(e));
        end
        out_bytes++;
        if (udp_tlast_out) out_pkts++;
        prev_hs = ~udp_tlast_out;
      end
    end
  end

  task automatic send_pkt(input int len, input logic [31:0] ip,
                          input logic [7:0] seed, input bit exp_out,
                          input bit with_last);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = seed + 8'(i * 3);
      udp_rvalid_in = 1'b1;
      udp_rdata_in = d;
      udp_rlast_in = with_last && (i == len - 1);
      udp_rip_in = (i == 0) ? ip : 32'hDEAD_0000 + 32'(i);
      if (exp_out) sb.push_back({d, (i == len - 1), ip});
      @(posedge logic_clk);
      #1;
    end
    udp_rvalid_in = 1'b0;
    udp_rlast_in = 1'b0;
    last_edge = cyc;
  endtask

  task automatic chk_zero_outs(input string nm);
    chk(nm, {udp_rready_out, udp_tvalid_out, udp_tlast_out,
             udp_tdata_out, udp_tip_out}, 64'd0);
    chk({nm, "_cnt"}, {pkt_cnt_out, drop_cnt_out}, 64'd0);
  endtask

  task automatic do_reset();
    logic_rst = 1'b1;
    udp_rvalid_in = 1'b0;
    udp_rlast_in = 1'b0;
    repeat (2) @(posedge logic_clk);
    #1;
    chk_zero_outs("reset_outs");
    sb.delete();
    logic_rst = 1'b0;
    out_bytes = 0;
    out_pkts = 0;
    @(posedge logic_clk);
    #1;
    chk("rready_after_reset", 64'(udp_rready_out), 64'd1);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0 || udp_tvalid_out) && n < max_cyc) begin
      @(posedge logic_clk);
      #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge logic_clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    udp_tready_in = 1'b1;
    @(posedge logic_clk);
    #1;

    // 64-byte packet, latency and content
    do_reset();
    send_pkt(64, 32'hC0A8_0001, 8'h10, 1, 1);
    lat_arm = 1;
    wait_drain(2000);
    chk("t1_pkt", 64'(pkt_cnt_out), 64'd1);
    chk("t1_drop", 64'(drop_cnt_out), 64'd0);
    chk("t1_bytes", 64'(out_bytes), 64'd64);

    // oversize packet then a small one
    do_reset();
    send_pkt(1473, 32'h0A00_0001, 8'h22, 0, 1);
    send_pkt(10, 32'h0A00_0002, 8'h77, 1, 1);
    wait_drain(2000);
    chk("t2_pkt", 64'(pkt_cnt_out), 64'd1);
    chk("t2_drop", 64'(drop_cnt_out), 64'd1);
    chk("t2_bytes", 64'(out_bytes), 64'd10);

    // buffer overflow with output stalled
    do_reset();
    udp_tready_in = 1'b0;
    send_pkt(1472, 32'h0B00_0001, 8'h01, 1, 1);
    for (int k = 0; k < 4; k++)
      send_pkt(1472, 32'h0B00_0002 + 32'(k), 8'h40, 0, 1);
    chk("t3_pkt", 64'(pkt_cnt_out), 64'd1);
    chk("t3_drop", 64'(drop_cnt_out), 64'd4);
    udp_tready_in = 1'b1;
    wait_drain(3000);
    chk("t3_bytes", 64'(out_bytes), 64'd1472);
    chk("t3_rd_ptr", 64'(dut.r_rd_ptr), 64'd1472);
    chk("t3_commit", 64'(dut.r_wr_commit), 64'd1472);

    // single-byte packet
    do_reset();
    send_pkt(1, 32'h0C00_0001, 8'hA5, 1, 1);
    wait_drain(100);
    chk("t4_pkt", 64'(pkt_cnt_out), 64'd1);
    chk("t4_bytes", 64'(out_bytes), 64'd1);

    // random backpressure, 20 packets
    do_reset();
    rand_tready = 1;
    sent = 0;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while ((sent - out_pkts) > 2 && n < 5000) begin
        @(posedge logic_clk);
        #1;
        n++;
      end
      chk("t5_pending", 64'((sent - out_pkts) > 2), 64'd0);
      send_pkt(int'($urandom_range(1, 64)), $urandom, 8'(k * 13), 1, 1);
      sent++;
    end
    wait_drain(5000);
    rand_tready = 0;
    @(posedge logic_clk);
    #2;
    udp_tready_in = 1'b1;
    chk("t5_pkt", 64'(pkt_cnt_out), 64'd20);
    chk("t5_drop", 64'(drop_cnt_out), 64'd0);
    chk("t5_out_pkts", 64'(out_pkts), 64'd20);

    // reset during output of pkt 2 and input of pkt 3
    do_reset();
    send_pkt(30, 32'h0D00_0001, 8'h05, 1, 1);
    wait_drain(200);
    send_pkt(40, 32'h0D00_0002, 8'h33, 1, 1);
    send_pkt(20, 32'h0D00_0003, 8'h99, 0, 0);
    chk("t6_mid_out", 64'(udp_tvalid_out), 64'd1);
    logic_rst = 1'b1;
    @(posedge logic_clk);
    #1;
    chk_zero_outs("t6_rst");
    sb.delete();
    logic_rst = 1'b0;
    out_bytes = 0;
    out_pkts = 0;
    @(posedge logic_clk);
    #1;
    send_pkt(50, 32'h0D00_0004, 8'h61, 1, 1);
    wait_drain(500);
    chk("t6_pkt", 64'(pkt_cnt_out), 64'd1);
    chk("t6_bytes", 64'(out_bytes), 64'd50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
